instr_stream_decoder: RTL and testbench
=======================================

INSTR_STREAM_DECODER -- requirements
Module: instr_stream_decoder

Interface
REQ-001 Parameter HW_WIDTH, default 16: halfword width in bits.
REQ-002 Parameter FETCH_HW, default 2: halfwords per input beat.
REQ-003 Parameter BUF_HW, default 8: buffer depth in halfwords; power of 2, >= FETCH_HW+2.
REQ-004 Parameter GROUP_HI, default 15 and GROUP_LO, default 14: group-field bit span within hw0; GROUP_HI-GROUP_LO = 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous discard of all buffered halfwords.
REQ-008 in_valid  input  1  input beat offered.
REQ-009 in_ready  output  1  input beat will be accepted.
REQ-010 in_data  input  FETCH_HW*HW_WIDTH  halfwords; halfword 0 (oldest) in most-significant position.
REQ-011 in_count  input  clog2(FETCH_HW+1)  number of valid halfwords in in_data, taken from the MS end; 0 legal (no-op beat).
REQ-012 out_valid  output  1  complete instruction at buffer head.
REQ-013 out_ready  input  1  consumer takes the instruction.
REQ-014 out_instr  output  3*HW_WIDTH  {hw0,hw1,hw2}; halfwords beyond out_len driven 0.
REQ-015 out_len  output  2  instruction length in halfwords, 1..3.
REQ-016 out_group  output  2  hw0[GROUP_HI:GROUP_LO].
REQ-017 out_imm_s16  output  2*HW_WIDTH  hw1 sign-extended.
REQ-018 out_imm_32  output  2*HW_WIDTH  {hw1,hw2}, no extension.
REQ-019 level  output  clog2(BUF_HW+1)  current occupancy in halfwords.

Function
REQ-020 Length by group of head halfword: group 0 -> 1; groups 1 and 2 -> 2; group 3 -> 3.
REQ-021 Buffer is a circular FIFO of halfwords (read pointer, write pointer, count); pointers wrap modulo BUF_HW.
REQ-022 in_ready = (level <= BUF_HW-FETCH_HW) and not flush; derived from current-cycle level, independent of same-cycle pop.
REQ-023 Push on in_valid && in_ready: in_count halfwords appended in order, halfword 0 first; level increases by in_count the next cycle.
REQ-024 out_valid = (level >= 1) and (level >= length of head) and not flush; combinational from registered buffer state.
REQ-025 out_instr, out_len, out_group, out_imm_* combinational from head halfwords; imm fields computed from zero-filled hw1/hw2 when len < 3.
REQ-026 Pop on out_valid && out_ready: read pointer advances by out_len; level decreases by out_len next cycle.
REQ-027 Simultaneous push and pop in one cycle: level_next = level + in_count - out_len.
REQ-028 Instruction may span input beats; no output until all its halfwords are buffered (latency: 1 cycle from completing beat to out_valid).
REQ-029 out_valid low: output fields undefined-but-stable-from-buffer; consumer ignores them.
REQ-030 flush high: no push, no pop, in_ready=0, out_valid=0; next cycle level=0, pointers=0; flush overrides in_valid/out_ready.
REQ-031 Beat with in_valid and in_count=0 is accepted with no state change.
REQ-032 in_data/in_count must be held stable while in_valid && !in_ready; block never drops an offered beat.

Reset
REQ-033 rst_n low, asynchronously: read/write pointers 0, level 0, out_valid 0, in_ready 0 while rst_n low.
REQ-034 After rst_n deasserts: in_ready 1 in first cycle; buffer contents not cleared (not observable).
REQ-035 Reset mid-instruction discards all partial and complete instructions; no output of pre-reset data.

Verification (defaults HW_WIDTH=16, FETCH_HW=2, BUF_HW=8)
REQ-036 Reset: rst_n=0 -> out_valid=0, level=0, in_ready=0; release -> in_ready=1, level=0.
REQ-037 Push in_data=0x1234_5678, in_count=2, out_ready=1 -> next cycle out_valid=1, out_len=1, out_group=0, out_instr=0x1234_0000_0000; after pop head 0x5678 (group 1) -> out_valid=0, level=1.
REQ-038 Push 0xC001_AAAA (count 2), then 0xBBBB_0000 (count 1) -> out_valid only after second beat; out_len=3, out_imm_32=0xAAAA_BBBB, out_instr=0xC001_AAAA_BBBB.
REQ-039 Push 0x4000_8000 -> out_len=2, out_imm_s16=0xFFFF_8000.
REQ-040 out_ready=0, four beats count=2 -> level=8, in_ready=0; fifth beat held until one pop, then accepted; pointer wrap yields correct order.
REQ-041 flush=1 with in_valid=1, level=5 -> beat not accepted, out_valid=0; next cycle level=0; async rst_n pulse mid-stream -> level=0 immediately.

Source files
------------

// File: rtl/instr_stream_decoder.sv
// Halfword stream buffer that assembles variable-length (1..3 halfword)
// instructions from fetch beats and presents one decoded instruction per pop.
module instr_stream_decoder #(
    parameter int HW_WIDTH = 16,
    parameter int FETCH_HW = 2,
    parameter int BUF_HW   = 8,
    parameter int GROUP_HI = 15,
    parameter int GROUP_LO = 14
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FETCH_HW*HW_WIDTH-1:0]     in_data,
    input  logic [$clog2(FETCH_HW+1)-1:0]    in_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [3*HW_WIDTH-1:0]            out_instr,
    output logic [1:0]                       out_len,
    output logic [1:0]                       out_group,
    output logic [2*HW_WIDTH-1:0]            out_imm_s16,
    output logic [2*HW_WIDTH-1:0]            out_imm_32,
    output logic [$clog2(BUF_HW+1)-1:0]      level
);

    localparam int PW = $clog2(BUF_HW);
    localparam int LW = $clog2(BUF_HW+1);
    localparam int CW = $clog2(FETCH_HW+1);

    logic [HW_WIDTH-1:0] mem_q [BUF_HW];
    logic [HW_WIDTH-1:0] mem_d [BUF_HW];
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [LW-1:0]       level_q, level_d;

    logic [HW_WIDTH-1:0] hw0, hw1, hw2;
    logic [HW_WIDTH-1:0] hw1_z, hw2_z;
    logic [1:0]          grp;
    logic [1:0]          len;
    logic                push, pop;

    always_comb begin
        hw0 = mem_q[rptr_q];
        hw1 = mem_q[rptr_q + PW'(1)];
        hw2 = mem_q[rptr_q + PW'(2)];
        grp = hw0[GROUP_HI:GROUP_LO];
        case (grp)
            2'd0:    len = 2'd1;
            2'd1,
            2'd2:    len = 2'd2;
            default: len = 2'd3;
        endcase
        // Halfwords past the instruction end are zeroed before field extraction
        hw1_z = (len != 2'd1) ? hw1 : '0;
        hw2_z = (len == 2'd3) ? hw2 : '0;
    end

    assign out_instr   = {hw0, hw1_z, hw2_z};
    assign out_len     = len;
    assign out_group   = grp;
    assign out_imm_s16 = {{HW_WIDTH{hw1_z[HW_WIDTH-1]}}, hw1_z};
    assign out_imm_32  = {hw1_z, hw2_z};
    assign level       = level_q;

    // rst_n gating keeps in_ready low for the whole reset assertion
    assign in_ready  = rst_n && !flush &&
                       (level_q <= LW'(BUF_HW - FETCH_HW));
    assign out_valid = !flush && (level_q != '0) &&
                       (level_q >= LW'(len));

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                for (int i = 0; i < FETCH_HW; i++) begin
                    if (CW'(i) < in_count) begin
                        mem_d[wptr_q + PW'(i)] =
                            in_data[(FETCH_HW-1-i)*HW_WIDTH +: HW_WIDTH];
                    end
                end
                wptr_d = wptr_q + PW'(in_count);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(len);
            end
            level_d = level_q
                    + (push ? LW'(in_count) : '0)
                    - (pop ? LW'(len) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Directed bench for instr_stream_decoder: queue-based halfword model
// checked every cycle, plus hand-computed literal checks.
module tb_instr_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_instr;
    logic [1:0]  out_len;
    logic [1:0]  out_group;
    logic [31:0] out_imm_s16;
    logic [31:0] out_imm_32;
    logic [3:0]  level;

    int nvec = 0;
    int nerr = 0;
    int k;

    logic [15:0] mq[$];

    instr_stream_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_count   (in_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_len    (out_len),
        .out_group  (out_group),
        .out_imm_s16(out_imm_s16),
        .out_imm_32 (out_imm_32),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int mlen(input logic [15:0] h);
        if (h[15:14] == 2'd0) return 1;
        if (h[15:14] == 2'd3) return 3;
        return 2;
    endfunction

    function automatic bit mvalid();
        if (flush || mq.size() == 0) return 1'b0;
        return mq.size() >= mlen(mq[0]);
    endfunction

    // Model update: drain on reset/flush, else pop head instruction then append beat
    always @(negedge rst_n) mq.delete();

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            bit v;
            bit rdy;
            v   = mvalid();
            rdy = (mq.size() <= 6);
            if (v && out_ready) begin
                int n;
                n = mlen(mq[0]);
                for (int i = 0; i < n; i++) void'(mq.pop_front());
            end
            if (in_valid && rdy) begin
                for (int i = 0; i < int'(in_count); i++) begin
                    logic [15:0] h;
                    h = (i == 0) ? in_data[31:16] : in_data[15:0];
                    mq.push_back(h);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit          ev;
        int          n;
        logic [15:0] e1, e2;
        ev = rst_n && mvalid();
        check("level", level, mq.size());
        check("in_ready", in_ready,
              rst_n && !flush && (mq.size() <= 6));
        check("out_valid", out_valid, ev);
        if (ev) begin
            n  = mlen(mq[0]);
            e1 = (n >= 2) ? mq[1] : 16'h0;
            e2 = (n == 3) ? mq[2] : 16'h0;
            check("out_len", out_len, n);
            check("out_group", out_group, mq[0][15:14]);
            check("out_instr", out_instr, {mq[0], e1, e2});
            check("out_imm_s16", out_imm_s16,
                  {{16{e1[15]}}, e1});
            check("out_imm_32", out_imm_32, {e1, e2});
        end
    end

    task automatic drive(input bit v, input logic [31:0] d,
                         input logic [1:0] c);
        in_valid = v;
        in_data  = d;
        in_count = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(0, 32'h0, 2'd0);

        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_level", level, 0);

        // single-halfword instruction then a partial one left behind
        step();
        out_ready = 1'b1;
        drive(1, 32'h1234_5678, 2'd2);
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t37_valid", out_valid, 1);
        check("t37_len", out_len, 1);
        check("t37_group", out_group, 0);
        check("t37_instr", out_instr, 48'h1234_0000_0000);
        step();
        @(negedge clk);
        check("t37_valid2", out_valid, 0);
        check("t37_level", level, 1);

        step();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // zero-count beat is a no-op
        drive(1, 32'hFFFF_FFFF, 2'd0);
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("cnt0_level", level, 0);
        check("cnt0_valid", out_valid, 0);

        // three-halfword instruction split across two beats
        step();
        drive(1, 32'hC001_AAAA, 2'd2);
        step();
        drive(1, 32'hBBBB_0000, 2'd1);
        @(negedge clk);
        check("t38_early", out_valid, 0);
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t38_valid", out_valid, 1);
        check("t38_len", out_len, 3);
        check("t38_imm32", out_imm_32, 32'hAAAA_BBBB);
        check("t38_instr", out_instr, 48'hC001_AAAA_BBBB);
        step();

        drive(1, 32'h4000_8000, 2'd2);
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t39_len", out_len, 2);
        check("t39_imm_s16", out_imm_s16, 32'hFFFF_8000);
        step();

        // fill to capacity across the pointer wrap, then hold a beat
        out_ready = 1'b0;
        drive(1, 32'h0001_0002, 2'd2);
        step();
        drive(1, 32'h0003_0004, 2'd2);
        step();
        drive(1, 32'h0005_0006, 2'd2);
        step();
        drive(1, 32'h0007_0008, 2'd2);
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t40_full_level", level, 8);
        check("t40_full_ready", in_ready, 0);
        step();
        drive(1, 32'h0009_000A, 2'd2);
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t40_accept", in_ready, 1);
        check("t40_wait_cycles", k, 2);
        step();
        drive(0, 32'h0, 2'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check("t40_level", level, 7);
        check("t40_head", out_instr, 48'h0004_0000_0000);
        step();
        out_ready = 1'b1;
        repeat (7) step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t40_drained", level, 0);

        // flush overrides an offered beat
        step();
        drive(1, 32'h0001_0002, 2'd2);
        step();
        drive(1, 32'h0003_0004, 2'd2);
        step();
        drive(1, 32'h0005_0000, 2'd1);
        step();
        drive(1, 32'h1111_2222, 2'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t41_fl_ready", in_ready, 0);
        check("t41_fl_valid", out_valid, 0);
        check("t41_fl_level", level, 5);
        step();
        flush = 1'b0;
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t41_fl_after", level, 0);

        // asynchronous reset pulse mid-stream
        step();
        out_ready = 1'b0;
        drive(1, 32'h0001_0002, 2'd2);
        step();
        step();
        drive(0, 32'h0, 2'd0);
        @(negedge clk);
        check("t41_pre_rst", level, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t41_rst_level", level, 0);
        check("t41_rst_ready", in_ready, 0);
        check("t41_rst_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t41_rel_ready", in_ready, 1);
        check("t41_rel_level", level, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
